// File: rtl/module_button_event_if.sv
// Event bus between the debounced button level and its consumers.
// The master drives db_in. The slave (module_button_event) returns the registered event pulses and the held level.
interface module_button_event_if;
    logic db_in;
    logic press_pulse;
    logic release_pulse;
    logic click_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output db_in,
        input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
    );

    modport slave (
        input  db_in,
        output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/module_button_event.sv
// Turns one debounced button level into single-cycle press, release, click, long and repeat events.
// Every output is registered. Each output appears one cycle after the db_in edge that causes it.
module module_button_event #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input logic                  clk,
    input logic                  n_reset,
    module_button_event_if.slave bus
);
    localparam int MAX_CYCLES = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHORT, LONG} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          db_q;
    logic          armed;
    logic          rise, fall;
    logic          press_q, release_q, click_q, long_q, repeat_q, held_q;

    // armed stays low until db_in is seen low after reset.
    // A button already held when reset is released therefore gives no press.
    assign rise = bus.db_in & ~db_q & armed;
    assign fall = ~bus.db_in & db_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= IDLE;
            cnt       <= '0;
            db_q      <= 1'b0;
            armed     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            db_q      <= bus.db_in;
            armed     <= armed | ~bus.db_in;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= SHORT;
                        cnt     <= '0;
                        press_q <= 1'b1;
                        held_q  <= 1'b1;
                    end
                end
                // A fall is checked before the timeouts, so a release in the same cycle wins.
                SHORT: begin
                    if (fall) begin
                        state     <= IDLE;
                        release_q <= 1'b1;
                        click_q   <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (cnt == LONG_LAST) begin
                        state  <= LONG;
                        long_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (fall) begin
                        state     <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else if (REPEAT_EN && cnt == REP_LAST) begin
                        repeat_q <= 1'b1;
                        cnt      <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.click_pulse   = click_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;
endmodule

// File: tb/tb_module_button_event.sv
// Scoreboard bench for module_button_event. Two builds are driven by one stimulus: repeat enabled and repeat disabled.
// Stimulus pushes the expected {cycle, pulse vector} events. A monitor pops and compares each pulse it sees.
module tb_module_button_event;
    localparam logic [4:0] P  = 5'b10000;
    localparam logic [4:0] R  = 5'b01000;
    localparam logic [4:0] C  = 5'b00100;
    localparam logic [4:0] L  = 5'b00010;
    localparam logic [4:0] RP = 5'b00001;
    localparam int BOTH = 3, REP = 1, NOREP = 2;

    typedef struct {
        int         cyc;
        logic [4:0] vec;
    } exp_t;

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[2][$];
    logic [4:0] vec [2];
    logic       hld [2];

    module_button_event_if bif0 ();
    module_button_event_if bif1 ();

    module_button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b1)) u_dut (
        .clk(clk), .n_reset(n_reset), .bus(bif0.slave)
    );
    module_button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .REPEAT_EN(1'b0)) u_dut_norep (
        .clk(clk), .n_reset(n_reset), .bus(bif1.slave)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign vec[0] = {bif0.press_pulse, bif0.release_pulse, bif0.click_pulse, bif0.long_pulse, bif0.repeat_pulse};
    assign vec[1] = {bif1.press_pulse, bif1.release_pulse, bif1.click_pulse, bif1.long_pulse, bif1.repeat_pulse};
    assign hld[0] = bif0.held;
    assign hld[1] = bif1.held;

    // Monitor. A pulse vector with more than one bit set is compared as a whole.
    // This catches non-exclusive pulses, and a pulse that is too wide shows up as an unexpected event.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (vec[d] != 5'b0) begin
                tests++;
                if (q[d].size() == 0) begin
                    fails++;
                    $display("FAIL dut%0d unexpected_pulse cyc=%0d act=%b req=none", d, cyc, vec[d]);
                end else begin
                    exp_t e;
                    e = q[d].pop_front();
                    if (e.vec !== vec[d] || e.cyc != cyc) begin
                        fails++;
                        $display("FAIL dut%0d event act=%b@%0d req=%b@%0d", d, vec[d], cyc, e.vec, e.cyc);
                    end
                end
            end
        end
    end

    task automatic push(input int mask, input int at, input logic [4:0] v);
        exp_t e;
        e.cyc = at;
        e.vec = v;
        for (int d = 0; d < 2; d++)
            if (mask[d]) q[d].push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s act=%0h req=%0h", nm, act, req);
        end
    endtask

    task automatic chk_quiet(input string nm, input logic held_req);
        chk({nm, "_vec0"}, {3'b0, vec[0]}, 8'h00);
        chk({nm, "_vec1"}, {3'b0, vec[1]}, 8'h00);
        chk({nm, "_held0"}, {7'b0, hld[0]}, {7'b0, held_req});
        chk({nm, "_held1"}, {7'b0, hld[1]}, {7'b0, held_req});
    endtask

    task automatic drive(input logic v);
        bif0.db_in = v;
        bif1.db_in = v;
    endtask

    task automatic ncyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int c;

    initial begin
        drive(1'b0);
        // 1: reset held for 200 ns while db_in toggles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(i[0]);
            chk_quiet("reset", 1'b0);
        end
        drive(1'b0);
        @(negedge clk);
        n_reset = 1'b1;
        ncyc(3);
        chk_quiet("post_reset", 1'b0);

        // 2: short click, 3 cycles
        c = cyc;
        drive(1'b1);
        push(BOTH, c + 1, P);
        push(BOTH, c + 4, R | C);
        ncyc(2);
        chk("click_held0", {7'b0, hld[0]}, 8'h01);
        chk("click_held1", {7'b0, hld[1]}, 8'h01);
        ncyc(1);
        drive(1'b0);
        ncyc(3);
        chk_quiet("click_after", 1'b0);

        // 3: long press plus repeat, 20 cycles. The third repeat collides with the release.
        c = cyc;
        drive(1'b1);
        push(BOTH,  c + 1,  P);
        push(BOTH,  c + 9,  L);
        push(REP,   c + 13, RP);
        push(REP,   c + 17, RP);
        push(BOTH,  c + 21, R);
        ncyc(20);
        drive(1'b0);
        ncyc(4);

        // 4: the release lands in the cycle where long_pulse is due
        c = cyc;
        drive(1'b1);
        push(BOTH, c + 1, P);
        push(BOTH, c + 9, R | C);
        ncyc(8);
        drive(1'b0);
        ncyc(4);

        // 5: reset mid-hold, then the button stays pressed through reset exit
        c = cyc;
        drive(1'b1);
        push(BOTH, c + 1, P);
        ncyc(5);
        chk("midhold_held0", {7'b0, hld[0]}, 8'h01);
        n_reset = 1'b0;
        #1;
        chk_quiet("midhold_reset", 1'b0);
        ncyc(2);
        n_reset = 1'b1;
        ncyc(5);
        chk_quiet("held_through_reset", 1'b0);
        drive(1'b0);
        ncyc(2);
        c = cyc;
        drive(1'b1);
        push(BOTH, c + 1, P);
        push(BOTH, c + 3, R | C);
        ncyc(2);
        drive(1'b0);
        ncyc(4);

        // 6: hold for 30 cycles. The no-repeat build gives one long_pulse and then waits.
        c = cyc;
        drive(1'b1);
        push(BOTH, c + 1,  P);
        push(BOTH, c + 9,  L);
        push(REP,  c + 13, RP);
        push(REP,  c + 17, RP);
        push(REP,  c + 21, RP);
        push(REP,  c + 25, RP);
        push(REP,  c + 29, RP);
        push(BOTH, c + 31, R);
        ncyc(30);
        drive(1'b0);
        ncyc(6);
        chk_quiet("final", 1'b0);

        chk("pending0", 8'(q[0].size()), 8'h00);
        chk("pending1", 8'(q[1].size()), 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
